booth_mult_seq: RTL

Sequential 32×32 signed multiplier that computes its product through the existing combinational ALU instead of its own adder. The block sits beside the ALU in the execute stage: it drives the ALU operand and opcode inputs each cycle, consumes the ALU sum and overflow, and produces the low 32 bits of the product plus an exception flag. It uses radix-2 Booth recoding, one iteration per cycle for 32 cycles.

---
 rtl/booth_mult_seq.sv | 109 ++++++++++
 1 files changed

// File: rtl/booth_mult_seq.sv
// booth_mult_seq: sequential 32x32 signed radix-2 Booth multiplier.
// It has no adder of its own. It drives the shared execute-stage ALU
// through the alu_* ports and reads the sum and overflow back in the
// same cycle. It returns the low product word and an overflow flag.
module booth_mult_seq (
    input  logic        clock,
    input  logic        reset,
    input  logic        ctrl_MULT,
    input  logic [31:0] data_operandA,
    input  logic [31:0] data_operandB,
    output logic [31:0] data_result,
    output logic        data_exception,
    output logic        data_resultRDY,
    output logic [31:0] alu_operandA,
    output logic [31:0] alu_operandB,
    output logic [4:0]  alu_opcode,
    input  logic [31:0] alu_result,
    input  logic        alu_overflow
);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] RUN  = 2'd1;
    localparam logic [1:0] DONE = 2'd2;

    localparam logic [4:0] OP_ADD = 5'b00000;
    localparam logic [4:0] OP_SUB = 5'b00001;

    logic [1:0]  state;
    logic [31:0] h;
    logic [31:0] q;
    logic        q_1;
    logic [31:0] m;
    logic [5:0]  count;

    logic        sum_sign;
    logic [31:0] h_next;
    logic [31:0] q_next;

    // Booth recoding of {Q[0], q_1}: choose add M, subtract M or add 0 on the ALU
    always_comb begin
        alu_operandA = '0;
        alu_operandB = '0;
        alu_opcode   = OP_ADD;
        if (state == RUN) begin
            alu_operandA = h;
            unique case ({q[0], q_1})
                2'b01:   alu_operandB = m;
                2'b10: begin
                    alu_operandB = m;
                    alu_opcode   = OP_SUB;
                end
                default: alu_operandB = '0;
            endcase
        end
    end

    // Arithmetic right shift of {ALU sum, Q}. The incoming sign bit is
    // corrected by the ALU overflow, so a wrapped sum still shifts in
    // its true sign.
    always_comb begin
        sum_sign = alu_result[31] ^ alu_overflow;
        h_next   = {sum_sign, alu_result[31:1]};
        q_next   = {alu_result[0], q[31:1]};
    end

    assign data_resultRDY = (state == DONE);

    // FSM, product register, iteration counter and result registers
    always_ff @(posedge clock) begin
        if (reset) begin
            state          <= IDLE;
            h              <= '0;
            q              <= '0;
            q_1            <= 1'b0;
            m              <= '0;
            count          <= '0;
            data_result    <= '0;
            data_exception <= 1'b0;
        end else begin
            unique case (state)
                RUN: begin
                    h     <= h_next;
                    q     <= q_next;
                    q_1   <= q[0];
                    count <= count + 6'd1;
                    if (count == 6'd31) begin
                        state          <= DONE;
                        data_result    <= q_next;
                        data_exception <= (h_next != {32{q_next[31]}});
                    end
                end
                IDLE, DONE: begin
                    if (ctrl_MULT) begin
                        state <= RUN;
                        m     <= data_operandA;
                        h     <= '0;
                        q     <= data_operandB;
                        q_1   <= 1'b0;
                        count <= '0;
                    end else begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
